// File: rtl/spmmio_arbiter.sv
// Two-master Wishbone arbiter with round-robin grant held per cycle and a bus watchdog.
// Latency: grant 1 cycle after cyc rises; slave strobe/ack/err paths are combinational.
// Backpressure: the non-owner waits with cyc high; a stalled access is ended with err after TIMEOUT cycles.
module spmmio_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:23] m0_adr_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic [0:3]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic [0:31] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [0:23] m1_adr_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic [0:3]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic [0:31] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [0:31] m_dat_o,
  output logic [0:23] s_adr_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic [0:3]  s_sel_o,
  output logic        s_we_o,
  output logic [0:31] s_dat_o,
  input  logic        s_ack_i,
  input  logic [0:31] s_dat_i,
  output logic [1:0]  owner
);

  // Encoding doubles as the debug owner code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             own_cyc, own_stb;
  logic             timeout;

  // Slave-side mux: owner's signals, master 0 addressing when nobody owns the bus.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_adr_o = m0_adr_i;
    s_sel_o = m0_sel_i;
    s_we_o  = m0_we_i;
    s_dat_o = m0_dat_i;
    case (state_q)
      OWN0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
      end
      OWN1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        s_adr_o = m1_adr_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  // Watchdog fires only when no ack arrives on the last permitted cycle (ack wins ties).
  assign timeout = own_stb & ~s_ack_i & (cnt_q == CNT_W'(TIMEOUT - 1));

  // The strobe is withheld for one cycle after a timeout so the stalled access is abandoned.
  assign s_cyc_o = own_cyc;
  assign s_stb_o = own_cyc & own_stb & ~abort_q;
  assign m_dat_o = s_dat_i;
  assign owner   = state_q;

  // Responses go only to the owner; held low while reset is asserted.
  assign m0_ack_o = reset & s_ack_i & (state_q == OWN0) & m0_stb_i;
  assign m1_ack_o = reset & s_ack_i & (state_q == OWN1) & m1_stb_i;
  assign m0_err_o = reset & timeout & (state_q == OWN0);
  assign m1_err_o = reset & timeout & (state_q == OWN1);

  // Next grant: round-robin on ties from IDLE, direct hand-over when the owner drops cyc.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_grant_q ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          last_grant_d = 1'b0;
          state_d      = m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          last_grant_d = 1'b1;
          state_d      = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog count: restarts on idle strobe, ack, timeout or hand-over; else counts strobed cycles.
  always_comb begin
    if ((state_d != state_q) || !own_stb || s_ack_i || timeout) cnt_d = '0;
    else                                                        cnt_d = cnt_q + CNT_W'(1);
    abort_d = timeout;
  end

  // State, fairness flag and watchdog registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
    end
  end

endmodule

// File: tb/tb_spmmio_arbiter.sv
// Bench for spmmio_arbiter: directed scenarios plus randomized traffic against a cycle model.
// Latency: model state advances on each clock edge; outputs compared on the falling edge.
// Backpressure: slave ack is driven randomly or by scenario; watchdog uses TIMEOUT=8.
module tb_spmmio_arbiter;
  localparam int TMO = 8;

  logic        clk;
  logic        reset;
  logic [0:23] m0_adr_i, m1_adr_i;
  logic        m0_stb_i, m0_cyc_i, m0_we_i, m1_stb_i, m1_cyc_i, m1_we_i;
  logic [0:3]  m0_sel_i, m1_sel_i;
  logic [0:31] m0_dat_i, m1_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [0:31] m_dat_o;
  logic [0:23] s_adr_o;
  logic        s_stb_o, s_cyc_o, s_we_o;
  logic [0:3]  s_sel_o;
  logic [0:31] s_dat_o;
  logic        s_ack_i;
  logic [0:31] s_dat_i;
  logic [1:0]  owner;

  int checks = 0;
  int failures = 0;

  spmmio_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m_dat_o(m_dat_o), .s_adr_o(s_adr_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i),
    .s_dat_i(s_dat_i), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner as an integer (-1 none), waiting-cycle count, abandon flag.
  int mdl_owner = -1;
  int mdl_last  = 0;
  int mdl_wait  = 0;
  bit mdl_abort = 1'b0;
  logic mo_cyc, mo_stb, e_tmo;
  logic e_cyc, e_stb, e_ack0, e_ack1, e_err0, e_err1;
  logic [1:0]  e_owner;
  logic [0:23] e_adr;
  logic [0:3]  e_sel;
  logic [0:31] e_dat;

  always_comb begin
    mo_cyc = 1'b0;
    mo_stb = 1'b0;
    if (mdl_owner == 0) begin mo_cyc = m0_cyc_i; mo_stb = m0_stb_i; end
    if (mdl_owner == 1) begin mo_cyc = m1_cyc_i; mo_stb = m1_stb_i; end
    e_tmo   = (mdl_owner >= 0) && mo_stb && (mdl_wait == TMO - 1) && !s_ack_i;
    e_cyc   = mo_cyc;
    e_stb   = mo_cyc && mo_stb && !mdl_abort;
    e_owner = (mdl_owner == 0) ? 2'b01 : (mdl_owner == 1) ? 2'b10 : 2'b00;
    e_ack0  = reset && s_ack_i && (mdl_owner == 0) && m0_stb_i;
    e_ack1  = reset && s_ack_i && (mdl_owner == 1) && m1_stb_i;
    e_err0  = reset && e_tmo && (mdl_owner == 0);
    e_err1  = reset && e_tmo && (mdl_owner == 1);
    e_adr   = (mdl_owner == 1) ? m1_adr_i : m0_adr_i;
    e_sel   = (mdl_owner == 1) ? m1_sel_i : m0_sel_i;
    e_dat   = (mdl_owner == 1) ? m1_dat_i : m0_dat_i;
  end

  always @(posedge clk) begin
    int nxt;
    if (!reset) begin
      mdl_owner <= -1; mdl_last <= 0; mdl_wait <= 0; mdl_abort <= 1'b0;
    end else begin
      nxt = mdl_owner;
      if (mdl_owner < 0) begin
        if (m0_cyc_i && m1_cyc_i) nxt = 1 - mdl_last;
        else if (m0_cyc_i)        nxt = 0;
        else if (m1_cyc_i)        nxt = 1;
      end else if (!mo_cyc) begin
        mdl_last <= mdl_owner;
        nxt = ((mdl_owner == 0) ? m1_cyc_i : m0_cyc_i) ? 1 - mdl_owner : -1;
      end
      if (nxt != mdl_owner || mdl_owner < 0 || !mo_stb || s_ack_i || e_tmo) mdl_wait <= 0;
      else mdl_wait <= mdl_wait + 1;
      mdl_abort <= e_tmo;
      mdl_owner <= nxt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'h0; m0_adr_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'h0; m1_adr_i = '0; m1_dat_i = '0;
    s_ack_i = 0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
    tick(); tick();
    @(negedge clk);
    checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL rst_s_cyc got %b want 0", s_cyc_o); end
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL rst_owner got %b want 00", owner); end
    checks++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0) begin failures++; $display("FAIL rst_ackerr got %b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
    tick();
    s_ack_i = 0;
    reset = 1;
    tick();
    @(negedge clk);
    checks++; if (owner !== 2'b10) begin failures++; $display("FAIL rst_first_grant got %b want 10", owner); end
    checks++; if (s_cyc_o !== 1'b1) begin failures++; $display("FAIL rst_grant_cyc got %b want 1", s_cyc_o); end
    tick();
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_single_write();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 24'h010000; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF;
    @(negedge clk);
    checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL wr_pre_grant_cyc got %b want 0", s_cyc_o); end
    tick();
    @(negedge clk);
    checks++; if (owner !== 2'b01) begin failures++; $display("FAIL wr_owner got %b want 01", owner); end
    checks++; if ({s_stb_o, s_we_o, s_adr_o, s_dat_o} !== {1'b1, 1'b1, 24'h010000, 32'hDEADBEEF})
      begin failures++; $display("FAIL wr_slave_side got stb=%b we=%b adr=%h dat=%h want 1 1 010000 deadbeef", s_stb_o, s_we_o, s_adr_o, s_dat_o); end
    tick();
    s_ack_i = 1; s_dat_i = 32'h12345678;
    @(negedge clk);
    checks++; if (m0_ack_o !== 1'b1) begin failures++; $display("FAIL wr_m0_ack got %b want 1", m0_ack_o); end
    checks++; if (m1_ack_o !== 1'b0) begin failures++; $display("FAIL wr_m1_ack got %b want 0", m1_ack_o); end
    checks++; if (m_dat_o !== 32'h12345678) begin failures++; $display("FAIL wr_m_dat got %h want 12345678", m_dat_o); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL wr_ack_once got %b want 0", m0_ack_o); end
    tick();
    @(negedge clk);
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL wr_release got %b want 00", owner); end
  endtask

  task automatic test_back_to_back();
    int got[$];
    int exp_g[4] = '{2, 1, 2, 1};
    int last_o = 0;
    int issued0 = 1, issued1 = 1;
    bit gap = 0, drop0 = 0, drop1 = 0, ack0 = 0, ack1 = 0;
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    for (int c = 0; c < 60 && got.size() < 4; c++) begin
      tick();
      if (drop0) begin drop0 = 0; if (issued0 < 2) begin m0_cyc_i = 1; m0_stb_i = 1; issued0++; end end
      if (drop1) begin drop1 = 0; if (issued1 < 2) begin m1_cyc_i = 1; m1_stb_i = 1; issued1++; end end
      if (ack0) begin m0_cyc_i = 0; m0_stb_i = 0; drop0 = 1; end
      if (ack1) begin m1_cyc_i = 0; m1_stb_i = 0; drop1 = 1; end
      s_ack_i = (owner == 2'b01 && m0_stb_i) || (owner == 2'b10 && m1_stb_i);
      @(negedge clk);
      if (owner != 2'b00 && int'(owner) != last_o) begin got.push_back(int'(owner)); last_o = int'(owner); end
      if (owner == 2'b00 && got.size() > 0 && got.size() < 4) gap = 1;
      ack0 = m0_ack_o; ack1 = m1_ack_o;
    end
    checks++; if (got.size() != 4) begin failures++; $display("FAIL b2b_grant_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        checks++; if (got[i] != exp_g[i]) begin failures++; $display("FAIL b2b_grant%0d got %0d want %0d", i, got[i], exp_g[i]); end
      end
    end
    checks++; if (gap) begin failures++; $display("FAIL b2b_idle_gap got 1 want 0"); end
    tick();
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_timeout();
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      checks++; if (m0_err_o !== (k == TMO)) begin failures++; $display("FAIL tmo_err_k%0d got %b want %b", k, m0_err_o, (k == TMO)); end
      checks++; if (m1_err_o !== 1'b0) begin failures++; $display("FAIL tmo_m1_err_k%0d got %b want 0", k, m1_err_o); end
      tick();
      if (k == 1) begin m1_cyc_i = 1; m1_stb_i = 1; end
    end
    @(negedge clk);
    checks++; if ({s_cyc_o, s_stb_o, m0_err_o} !== 3'b100) begin failures++; $display("FAIL tmo_abandon got cyc,stb,err=%b want 100", {s_cyc_o, s_stb_o, m0_err_o}); end
    tick();
    m0_cyc_i = 0; m0_stb_i = 0;
    @(negedge clk);
    checks++; if ({owner, s_cyc_o} !== 3'b010) begin failures++; $display("FAIL tmo_drop got owner,cyc=%b want 010", {owner, s_cyc_o}); end
    tick();
    @(negedge clk);
    checks++; if (owner !== 2'b10) begin failures++; $display("FAIL tmo_handover got %b want 10", owner); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_ack_on_timeout();
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    for (int k = 1; k <= TMO; k++) begin
      if (k == TMO) s_ack_i = 1;
      @(negedge clk);
      if (k == TMO) begin
        checks++; if ({m0_ack_o, m0_err_o} !== 2'b10) begin failures++; $display("FAIL ackwin got ack,err=%b want 10", {m0_ack_o, m0_err_o}); end
      end
      tick();
    end
    s_ack_i = 0;
    @(negedge clk);
    checks++; if ({s_stb_o, m0_err_o} !== 2'b10) begin failures++; $display("FAIL ackwin_no_abandon got stb,err=%b want 10", {s_stb_o, m0_err_o}); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_reset_midaccess();
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    s_ack_i = 1;
    reset = 0;
    @(negedge clk);
    checks++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0) begin failures++; $display("FAIL midrst_ack got %b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
    tick();
    @(negedge clk);
    checks++; if ({owner, s_cyc_o, s_stb_o, m1_ack_o} !== 5'b0) begin failures++; $display("FAIL midrst_outputs got %b want 00000", {owner, s_cyc_o, s_stb_o, m1_ack_o}); end
    tick();
    idle_inputs();
    reset = 1;
    tick();
    @(negedge clk);
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL midrst_idle got %b want 00", owner); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) < 12) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(99) < 12) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i & (m0_stb_i ^ ($urandom_range(9) == 0) | ~m0_stb_i & ($urandom_range(1) == 0));
      m1_stb_i = m1_cyc_i & (m1_stb_i ^ ($urandom_range(9) == 0) | ~m1_stb_i & ($urandom_range(1) == 0));
      m0_adr_i = 24'($urandom()); m1_adr_i = 24'($urandom());
      m0_sel_i = 4'($urandom());  m1_sel_i = 4'($urandom());
      m0_we_i = 1'($urandom());   m1_we_i = 1'($urandom());
      m0_dat_i = $urandom();      m1_dat_i = $urandom();
      s_dat_i = $urandom();
      s_ack_i = ((c / 500) % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      reset = ($urandom_range(299) != 0);
      @(negedge clk);
      checks++; if (owner !== e_owner) begin failures++; $display("FAIL rnd_owner c%0d got %b want %b", c, owner, e_owner); end
      checks++; if (s_cyc_o !== e_cyc) begin failures++; $display("FAIL rnd_s_cyc c%0d got %b want %b", c, s_cyc_o, e_cyc); end
      checks++; if (s_stb_o !== e_stb) begin failures++; $display("FAIL rnd_s_stb c%0d got %b want %b", c, s_stb_o, e_stb); end
      checks++; if ({m0_ack_o, m1_ack_o} !== {e_ack0, e_ack1}) begin failures++; $display("FAIL rnd_ack c%0d got %b want %b", c, {m0_ack_o, m1_ack_o}, {e_ack0, e_ack1}); end
      checks++; if ({m0_err_o, m1_err_o} !== {e_err0, e_err1}) begin failures++; $display("FAIL rnd_err c%0d got %b want %b", c, {m0_err_o, m1_err_o}, {e_err0, e_err1}); end
      checks++; if (s_adr_o !== e_adr) begin failures++; $display("FAIL rnd_adr c%0d got %h want %h", c, s_adr_o, e_adr); end
      checks++; if (s_sel_o !== e_sel) begin failures++; $display("FAIL rnd_sel c%0d got %h want %h", c, s_sel_o, e_sel); end
      checks++; if (s_dat_o !== e_dat) begin failures++; $display("FAIL rnd_dat c%0d got %h want %h", c, s_dat_o, e_dat); end
      checks++; if (m_dat_o !== s_dat_i) begin failures++; $display("FAIL rnd_m_dat c%0d got %h want %h", c, m_dat_o, s_dat_i); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_timeout();
    test_ack_on_timeout();
    test_reset_midaccess();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
